result_accum: RTL and testbench

RESULT_ACCUM -- requirements
Module: result_accum

---
 rtl/result_accum_pkg.sv | 14 +
 rtl/result_accum.sv | 114 +++++++++++
 tb/tb_result_accum.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/result_accum_pkg.sv
// Shared types and constants for the frame result accumulator.
package result_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned ACC_W_DEFAULT = 32;
  localparam int unsigned SAMPLE_W      = 17;
  localparam int unsigned CNT_W         = 9;

endpackage

// File: rtl/result_accum.sv
// Accumulates 17-bit {carry,sum} adder results over a frame of 1..256 samples
// and holds the total, carry count and wrap flag until downstream takes it.
module result_accum
  import result_accum_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_sum,
  input  logic             in_carry,
  output logic             in_ready,
  input  logic [7:0]       frame_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [8:0]       out_carry_cnt,
  output logic             out_ovf
);

  state_t                state;
  state_t                state_nxt;

  logic [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]      carry_cnt;
  logic [CNT_W-1:0]      samp_cnt;
  logic [CNT_W-1:0]      len_q;
  logic                  ovf;

  logic                  accept;
  logic [SAMPLE_W-1:0]   sample;
  logic [ACC_W:0]        sum_ext;
  logic [CNT_W-1:0]      samp_cnt_inc;
  logic [CNT_W-1:0]      len_eff;

  assign in_ready     = (state != HOLD);
  assign accept       = in_valid && in_ready;
  assign sample       = {in_carry, in_sum};
  // Extra top bit of the widened add is the wrap indication.
  assign sum_ext      = {1'b0, acc} + (ACC_W + 1)'(sample);
  assign samp_cnt_inc = samp_cnt + 9'd1;
  assign len_eff      = (frame_len == 8'd0) ? 9'd256 : {1'b0, frame_len};

  assign out_valid     = (state == HOLD);
  assign out_total     = acc;
  assign out_carry_cnt = carry_cnt;
  assign out_ovf       = ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (len_eff == 9'd1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && (samp_cnt_inc == len_q)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      carry_cnt <= '0;
      samp_cnt  <= '0;
      len_q     <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            len_q     <= len_eff;
            acc       <= ACC_W'(sample);
            carry_cnt <= {8'd0, in_carry};
            samp_cnt  <= 9'd1;
            ovf       <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc       <= sum_ext[ACC_W-1:0];
            carry_cnt <= carry_cnt + {8'd0, in_carry};
            samp_cnt  <= samp_cnt_inc;
            if (sum_ext[ACC_W]) begin
              ovf <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_accum.sv
// Directed bench for result_accum: a 32-bit and a 17-bit instance share stimulus.
module tb_result_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_sum;
  logic        in_carry;
  logic [7:0]  frame_len;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_total;
  logic [8:0]  out_carry_cnt;
  logic        out_ovf;

  logic        in_ready_w17;
  logic        out_valid_w17;
  logic [16:0] out_total_w17;
  logic [8:0]  out_carry_cnt_w17;
  logic        out_ovf_w17;

  int checks;
  int failures;

  result_accum #(.ACC_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_sum        (in_sum),
    .in_carry      (in_carry),
    .in_ready      (in_ready),
    .frame_len     (frame_len),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_total     (out_total),
    .out_carry_cnt (out_carry_cnt),
    .out_ovf       (out_ovf)
  );

  result_accum #(.ACC_W(17)) dut_w17 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_sum        (in_sum),
    .in_carry      (in_carry),
    .in_ready      (in_ready_w17),
    .frame_len     (frame_len),
    .out_valid     (out_valid_w17),
    .out_ready     (out_ready),
    .out_total     (out_total_w17),
    .out_carry_cnt (out_carry_cnt_w17),
    .out_ovf       (out_ovf_w17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one sample and step to the next falling edge; in_valid stays high.
  task automatic send(input logic carry, input logic [15:0] sum);
    in_valid = 1'b1;
    in_carry = carry;
    in_sum   = sum;
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = 1'b0;
    frame_len = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_total", 64'(out_total), 64'd0);
    check("rst_carry_cnt", 64'(out_carry_cnt), 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Four-sample frame, latency of result
    frame_len = 8'd4;
    send(1'b0, 16'h0001);
    send(1'b1, 16'hFFFF);
    send(1'b0, 16'h0010);
    check("f4_valid_before_last", 64'(out_valid), 64'd0);
    send(1'b0, 16'h0000);
    in_valid = 1'b0;
    check("f4_out_valid", 64'(out_valid), 64'd1);
    check("f4_out_total", 64'(out_total), 64'h20010);
    check("f4_carry_cnt", 64'(out_carry_cnt), 64'd1);
    check("f4_ovf", 64'(out_ovf), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("f4_after_hs_valid", 64'(out_valid), 64'd0);

    // 256-sample frame; frame_len changes mid-frame must not matter
    frame_len = 8'd0;
    send(1'b1, 16'hFFFF);
    frame_len = 8'd5;
    for (int i = 1; i < 255; i++) send(1'b1, 16'hFFFF);
    check("f256_valid_at_255", 64'(out_valid), 64'd0);
    send(1'b1, 16'hFFFF);
    in_valid = 1'b0;
    check("f256_out_valid", 64'(out_valid), 64'd1);
    check("f256_out_total", 64'(out_total), 64'h1FFFF00);
    check("f256_carry_cnt", 64'(out_carry_cnt), 64'd256);
    check("f256_ovf", 64'(out_ovf), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Two-sample frame: 17-bit instance wraps, then backpressure for 10 cycles
    frame_len = 8'd2;
    send(1'b1, 16'hFFFF);
    send(1'b0, 16'h0002);
    check("w17_out_total", 64'(out_total_w17), 64'h00001);
    check("w17_ovf", 64'(out_ovf_w17), 64'd1);
    check("w32_out_total", 64'(out_total), 64'h20001);
    check("w32_ovf", 64'(out_ovf), 64'd0);
    in_valid = 1'b1;
    in_carry = 1'b0;
    in_sum   = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_total", 64'(out_total), 64'h20001);
      check("bp_carry_cnt", 64'(out_carry_cnt), 64'd1);
      @(negedge clk);
    end
    frame_len = 8'd1;
    in_sum    = 16'h0007;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_cycle_no_accept", 64'(out_valid), 64'd0);
    check("hs_next_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_hs_out_valid", 64'(out_valid), 64'd1);
    check("post_hs_out_total", 64'(out_total), 64'h7);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset mid-frame discards partial result
    frame_len = 8'd4;
    send(1'b1, 16'h0100);
    send(1'b0, 16'h0200);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_total", 64'(out_total), 64'd0);
    @(negedge clk);
    check("midrst_still_idle", 64'(out_valid), 64'd0);
    frame_len = 8'd1;
    send(1'b0, 16'h0005);
    in_valid = 1'b0;
    check("midrst_new_valid", 64'(out_valid), 64'd1);
    check("midrst_new_total", 64'(out_total), 64'h5);
    check("midrst_new_carry", 64'(out_carry_cnt), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);

    // Single-sample frames streaming: one result every two cycles
    frame_len = 8'd1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("stream_idle_valid", 64'(out_valid), 64'd0);
      in_carry = k[0];
      in_sum   = 16'(16'h0A00 + k);
      @(negedge clk);
      check("stream_hold_valid", 64'(out_valid), 64'd1);
      check("stream_total", 64'(out_total), 64'({k[0], 16'(16'h0A00 + k)}));
      check("stream_carry", 64'(out_carry_cnt), 64'(k[0]));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
